// File: rtl/trivium_xor_stage_pkg.sv
// Shared definitions for the Trivium keystream consumer: FSM state encoding
// and the cipher's fixed dimensions.
package trivium_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_HOLD   = 2'd3
    } xor_state_e;

    localparam int TRIVIUM_WARMUP = 1152;
    localparam int KEY_W          = 80;
    localparam int IV_W           = 80;

endpackage

// File: rtl/ks_byte_packer.sv
// Collects serial keystream bits LSB-first into one byte. The bit count
// saturates at 7; `full` flags the shift that completes the byte.
module ks_byte_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [7:0] ks_byte,
    output logic       full
);

    logic [2:0] bit_cnt;

    assign full = shift_en && !clr && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_byte <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (clr) begin
            ks_byte <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (shift_en) begin
            ks_byte[bit_cnt] <= bit_in;
            if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/trivium_xor_stage.sv
// Gates the Trivium core through warm-up, packs its keystream into bytes and
// XORs each byte with one input stream byte onto a valid/ready output.
//
// state  | meaning
// IDLE   | after reset, core stalled, waiting for start
// WARMUP | core running, keystream discarded
// FILL   | core running, 8 keystream bits shifted into the packer
// HOLD   | core stalled, keystream byte waiting for one din byte
module trivium_xor_stage
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYCLES = TRIVIUM_WARMUP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ks_bit,
    output logic       core_en,
    output logic       busy,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready
);

    localparam int              WU_W    = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP_CYCLES);
    localparam logic [WU_W-1:0] WU_ONE  = WU_W'(1);

    xor_state_e      state, state_nxt;
    logic [WU_W-1:0] wu_cnt, wu_cnt_nxt;
    logic            xfer;
    logic            pk_clr;
    logic            pk_shift;
    logic            pk_full;
    logic [7:0]      ks_byte;

    assign core_en   = (state == ST_WARMUP) || (state == ST_FILL);
    assign busy      = (state == ST_WARMUP);
    assign din_ready = (state == ST_HOLD) && (!dout_valid || dout_ready);
    assign pk_shift  = (state == ST_FILL);
    // A start pulse outranks a coincident handshake.
    assign xfer      = din_valid && din_ready && !start;

    ks_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pk_clr),
        .shift_en (pk_shift),
        .bit_in   (ks_bit),
        .ks_byte  (ks_byte),
        .full     (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wu_cnt <= wu_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wu_cnt_nxt = wu_cnt;
        pk_clr     = 1'b0;
        if (start) begin
            state_nxt  = ST_WARMUP;
            wu_cnt_nxt = WU_LOAD;
            pk_clr     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_WARMUP: begin
                    wu_cnt_nxt = wu_cnt - WU_ONE;
                    if (wu_cnt == WU_ONE) begin
                        state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (pk_full) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (xfer) begin
                        state_nxt = ST_FILL;
                        pk_clr    = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
        end else if (start) begin
            dout_valid <= 1'b0;
        end else if (xfer) begin
            dout       <= din ^ ks_byte;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trivium_xor_stage.sv
// Bench for trivium_xor_stage: a short-warm-up instance fed by a scripted
// keystream source, plus a default-warm-up instance.
module tb_trivium_xor_stage;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       dout_ready = 1'b0;

   logic       start_a = 1'b0, load_a = 1'b0, ks_a;
   logic       core_en_a, busy_a, din_ready_a, dout_valid_a;
   logic [7:0] dout_a;

   logic       start_b = 1'b0, load_b = 1'b0, ks_b;
   logic       core_en_b, busy_b, din_ready_b, dout_valid_b;
   logic [7:0] dout_b;

   logic stream_a [0:511];
   logic stream_b [0:2047];
   int   idx_a = 0;
   int   idx_b = 0;

   int checks = 0;
   int failures = 0;
   int kidx_a = 0;

   always #5 clk = ~clk;

   // Stand-in cores: the keystream advances on every edge with enable high
   // and restarts when a fresh key/IV is loaded alongside start.
   always @(posedge clk) begin
      if (load_a) idx_a <= 0;
      else if (core_en_a) idx_a <= idx_a + 1;
      if (load_b) idx_b <= 0;
      else if (core_en_b) idx_b <= idx_b + 1;
   end
   assign ks_a = (idx_a < 512)  ? stream_a[idx_a] : 1'b0;
   assign ks_b = (idx_b < 2048) ? stream_b[idx_b] : 1'b0;

   trivium_xor_stage #(.WARMUP_CYCLES(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .ks_bit(ks_a),
      .core_en(core_en_a), .busy(busy_a),
      .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
      .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready)
   );

   trivium_xor_stage u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .ks_bit(ks_b),
      .core_en(core_en_b), .busy(busy_b),
      .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
      .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready)
   );

   // Byte k after start is keystream bits [W+8k, W+8k+7], first bit in bit 0.
   function automatic logic [7:0] exp_byte_a(int pos);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = stream_a[pos + i];
      return b;
   endfunction

   function automatic logic [7:0] exp_byte_b(int pos);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = stream_b[pos + i];
      return b;
   endfunction

   task automatic new_stream_a();
      for (int i = 0; i < 512; i++) stream_a[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      load_a  = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      load_a  = 1'b0;
   endtask

   task automatic wait_core_idle_a(output int n);
      n = 0;
      for (int c = 0; c < 60; c++) begin
         if (!core_en_a) break;
         n++;
         @(negedge clk);
      end
   endtask

   // Walks from cycle 1 after start until din_ready, counting enable/busy.
   task automatic run_warmup_a(output int en_cnt, output int busy_cnt,
                               output int first_en, output int rdy_cyc,
                               input logic [7:0] held, output int spur_bad);
      int cyc;
      cyc = 1; en_cnt = 0; busy_cnt = 0; first_en = 0; rdy_cyc = 0; spur_bad = 0;
      while (cyc < 40 && rdy_cyc == 0) begin
         if (core_en_a) begin
            en_cnt++;
            if (first_en == 0) first_en = cyc;
         end
         if (busy_a) busy_cnt++;
         if (dout_valid_a !== 1'b0 || dout_a !== held) spur_bad++;
         if (din_ready_a) rdy_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({core_en_a, busy_a, din_ready_a, dout_valid_a, dout_a} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=000",
                  {core_en_a, busy_a, din_ready_a, dout_valid_a, dout_a});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({core_en_a, busy_a, din_ready_a, dout_valid_a} !== 4'h0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0000",
                     {core_en_a, busy_a, din_ready_a, dout_valid_a});
         end
      end
   endtask

   task automatic test_basic();
      bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      int en_cnt, busy_cnt, first_en, rdy_cyc, spur_bad;
      new_stream_a();
      for (int i = 0; i < 8; i++) stream_a[4 + i] = pat[i];
      dout_ready = 1'b0;
      din_valid  = 1'b0;
      pulse_start_a();
      run_warmup_a(en_cnt, busy_cnt, first_en, rdy_cyc, 8'h00, spur_bad);
      checks++;
      if (en_cnt != 12) begin
         failures++;
         $display("FAIL basic_core_en_cycles got=%0d exp=12", en_cnt);
      end
      checks++;
      if (first_en != 1) begin
         failures++;
         $display("FAIL basic_core_en_first got=%0d exp=1", first_en);
      end
      checks++;
      if (busy_cnt != 4) begin
         failures++;
         $display("FAIL basic_busy_cycles got=%0d exp=4", busy_cnt);
      end
      checks++;
      if (rdy_cyc != 13) begin
         failures++;
         $display("FAIL basic_din_ready_cycle got=%0d exp=13", rdy_cyc);
      end
      din = 8'hFF;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      checks++;
      if ({dout_valid_a, dout_a} !== {1'b1, 8'hB2}) begin
         failures++;
         $display("FAIL basic_dout got=%b/%h exp=1/b2", dout_valid_a, dout_a);
      end
      checks++;
      if (din_ready_a !== 1'b0) begin
         failures++;
         $display("FAIL basic_ready_drop got=%b exp=0", din_ready_a);
      end
      kidx_a = 1;
   endtask

   task automatic test_backpressure();
      int n;
      logic [7:0] exp;
      wait_core_idle_a(n);
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL bp_fill_cycles got=%0d exp=8", n);
      end
      din = 8'h55;
      din_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (din_ready_a !== 1'b0) begin
         failures++;
         $display("FAIL bp_din_ready got=%b exp=0", din_ready_a);
      end
      checks++;
      if ({dout_valid_a, dout_a} !== {1'b1, 8'hB2}) begin
         failures++;
         $display("FAIL bp_dout_hold got=%b/%h exp=1/b2", dout_valid_a, dout_a);
      end
      din = 8'h00;
      dout_ready = 1'b1;
      #1;
      checks++;
      if (din_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL bp_ready_comb got=%b exp=1", din_ready_a);
      end
      exp = exp_byte_a(4 + 8 * kidx_a);
      @(negedge clk);
      dout_ready = 1'b0;
      din_valid  = 1'b0;
      checks++;
      if ({dout_valid_a, dout_a} !== {1'b1, exp}) begin
         failures++;
         $display("FAIL bp_drain_xfer got=%b/%h exp=1/%h", dout_valid_a, dout_a, exp);
      end
      kidx_a++;
   endtask

   task automatic test_throughput();
      int cyc, last, nx;
      logic xfer_now;
      logic [7:0] sent, exp;
      dout_ready = 1'b1;
      din = 8'($urandom);
      din_valid = 1'b1;
      cyc = 0; last = -1; nx = 0;
      while (cyc < 80 && nx < 4) begin
         xfer_now = din_ready_a;
         sent = din;
         @(negedge clk);
         cyc++;
         if (xfer_now) begin
            exp = sent ^ exp_byte_a(4 + 8 * kidx_a);
            checks++;
            if ({dout_valid_a, dout_a} !== {1'b1, exp}) begin
               failures++;
               $display("FAIL tp_dout got=%b/%h exp=1/%h", dout_valid_a, dout_a, exp);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 9) begin
                  failures++;
                  $display("FAIL tp_interval got=%0d exp=9", cyc - last);
               end
            end
            last = cyc;
            kidx_a++;
            nx++;
            din = 8'($urandom);
         end else if (last >= 0 && cyc == last + 1) begin
            checks++;
            if (dout_valid_a !== 1'b0) begin
               failures++;
               $display("FAIL tp_drain got=%b exp=0", dout_valid_a);
            end
         end
      end
      din_valid = 1'b0;
      checks++;
      if (nx != 4) begin
         failures++;
         $display("FAIL tp_timeout got=%0d exp=4", nx);
      end
   endtask

   task automatic test_abort_spurious();
      int en_cnt, busy_cnt, first_en, rdy_cyc, spur_bad;
      logic [7:0] held, exp;
      dout_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (din_ready_a) break;
         @(negedge clk);
      end
      din = 8'($urandom);
      din_valid = 1'b1;
      dout_ready = 1'b0;
      held = din ^ exp_byte_a(4 + 8 * kidx_a);
      @(negedge clk);
      din_valid = 1'b0;
      checks++;
      if ({dout_valid_a, dout_a} !== {1'b1, held}) begin
         failures++;
         $display("FAIL abort_pending got=%b/%h exp=1/%h", dout_valid_a, dout_a, held);
      end
      repeat (3) @(negedge clk);
      new_stream_a();
      din = 8'hA5;
      din_valid = 1'b1;
      pulse_start_a();
      checks++;
      if (dout_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL abort_discard got=%b exp=0", dout_valid_a);
      end
      run_warmup_a(en_cnt, busy_cnt, first_en, rdy_cyc, held, spur_bad);
      checks++;
      if (en_cnt != 12) begin
         failures++;
         $display("FAIL abort_core_en_cycles got=%0d exp=12", en_cnt);
      end
      checks++;
      if (rdy_cyc != 13) begin
         failures++;
         $display("FAIL abort_din_ready_cycle got=%0d exp=13", rdy_cyc);
      end
      checks++;
      if (spur_bad != 0) begin
         failures++;
         $display("FAIL spurious_input got=%0d exp=0", spur_bad);
      end
      exp = 8'hA5 ^ exp_byte_a(4);
      @(negedge clk);
      din_valid = 1'b0;
      checks++;
      if ({dout_valid_a, dout_a} !== {1'b1, exp}) begin
         failures++;
         $display("FAIL abort_first_byte got=%b/%h exp=1/%h", dout_valid_a, dout_a, exp);
      end
      kidx_a = 1;
   endtask

   task automatic test_reset_mid_hold();
      int n, idle_en;
      dout_ready = 1'b0;
      wait_core_idle_a(n);
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL rst_fill_cycles got=%0d exp=8", n);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({core_en_a, busy_a, din_ready_a, dout_valid_a, dout_a} !== 12'h000) begin
         failures++;
         $display("FAIL rst_async got=%h exp=000",
                  {core_en_a, busy_a, din_ready_a, dout_valid_a, dout_a});
      end
      @(negedge clk);
      rst_n = 1'b1;
      din_valid = 1'b1;
      dout_ready = 1'b1;
      idle_en = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (core_en_a || din_ready_a || dout_valid_a) idle_en++;
      end
      din_valid = 1'b0;
      checks++;
      if (idle_en != 0) begin
         failures++;
         $display("FAIL rst_stays_idle got=%0d exp=0", idle_en);
      end
      new_stream_a();
      pulse_start_a();
      checks++;
      if ({core_en_a, busy_a} !== 2'b11) begin
         failures++;
         $display("FAIL rst_resume got=%b exp=11", {core_en_a, busy_a});
      end
   endtask

   task automatic test_default_warmup();
      int cyc, en_cnt, rdy_cyc;
      logic [7:0] exp;
      for (int i = 0; i < 2048; i++) stream_b[i] = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      din_valid = 1'b0;
      dout_ready = 1'b1;
      start_b = 1'b1;
      load_b  = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      load_b  = 1'b0;
      cyc = 1; en_cnt = 0; rdy_cyc = 0;
      while (cyc < 1300 && rdy_cyc == 0) begin
         if (core_en_b) en_cnt++;
         if (din_ready_b) rdy_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (en_cnt != 1160) begin
         failures++;
         $display("FAIL dflt_core_en_cycles got=%0d exp=1160", en_cnt);
      end
      checks++;
      if (rdy_cyc != 1161) begin
         failures++;
         $display("FAIL dflt_din_ready_cycle got=%0d exp=1161", rdy_cyc);
      end
      exp = din ^ exp_byte_b(1152);
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      checks++;
      if ({dout_valid_b, dout_b} !== {1'b1, exp}) begin
         failures++;
         $display("FAIL dflt_dout got=%b/%h exp=1/%h", dout_valid_b, dout_b, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) stream_a[i] = 1'b0;
      for (int i = 0; i < 2048; i++) stream_b[i] = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_throughput();
      test_abort_spurious();
      test_reset_mid_hold();
      test_default_warmup();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trivium_xor_stage.md
# trivium_xor_stage

Downstream consumer of the Trivium keystream core. Gates the core's `enable` through the 1152-round warm-up, packs the serial keystream into bytes and XORs each byte with one data byte from a valid/ready input stream. The result goes out on a valid/ready output stream. Sits between the Trivium core and the byte-wide pin interface of the TinyTapeout top.

## Interface
- `WARMUP_CYCLES`, default 1152: enabled core cycles whose keystream is discarded after `start`; must be ≥ 1.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle pulse: key/IV freshly loaded into the core; begin warm-up.
- `ks_bit`  in  1  keystream bit from the core (`keystream_bit`).
- `core_en`  out  1  drives the core's `enable`.
- `busy`  out  1  high while in WARMUP.
- `din`  in  8  plaintext/ciphertext byte.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  stage can accept `din`.
- `dout`  out  8  `din ^ keystream_byte`.
- `dout_valid`  out  1  `dout` valid.
- `dout_ready`  in  1  sink accepts `dout`.

## Operation
- FSM states: IDLE, WARMUP, FILL, HOLD.
  - IDLE: `core_en`=0. On `start`, go to WARMUP and clear the warm-up counter.
  - WARMUP: `core_en`=1 and `busy`=1. Count the rising edges with `core_en`=1. After the `WARMUP_CYCLES`-th edge, go to FILL with bit count 0.
  - FILL: `core_en`=1. Shift `ks_bit` into the keystream byte on each edge; the first bit received is bit 0 (LSB first). After the 8th bit, go to HOLD.
  - HOLD: `core_en`=0, so the core stalls. `din_ready` = (state==HOLD) && (!dout_valid || dout_ready).
- A transfer occurs when `din_valid` && `din_ready` on an edge:
  - `dout` ← `din ^ ks_byte` and `dout_valid` ← 1.
  - State → FILL with bit count cleared.
- `dout_valid` clears on an edge where `dout_valid` && `dout_ready` and no new transfer happens. A simultaneous drain and transfer leaves `dout_valid`=1 with the new byte.
- `dout` stays stable while `dout_valid`=1 && `dout_ready`=0.
- `din_valid` while `din_ready`=0 is ignored; no state change.
- `start` in any non-IDLE state aborts and re-enters WARMUP:
  - Warm-up counter, bit count and `ks_byte` are cleared.
  - `dout_valid` ← 0, discarding any pending output.
- Each keystream byte is used exactly once; no keystream bit is skipped or reused.
- Warm-up counter width is `$clog2(WARMUP_CYCLES+1)`. The bit counter is 3 bits and saturates into the HOLD transition; it never wraps.
- Reset: state IDLE. `core_en`, `busy`, `din_ready` and `dout_valid` = 0. `dout` = 8'h00 and `ks_byte` = 0. Reset applies immediately (asynchronous), including mid-transfer.

## Timing
- `ks_bit` is sampled on every rising edge where `core_en`=1. The core advances on the same edge.
- `start` sampled at edge 0:
  - `core_en`=1 from cycle 1 for `WARMUP_CYCLES`+8 consecutive cycles.
  - `din_ready` rises in cycle `WARMUP_CYCLES`+9.
- Transfer to output: `dout_valid` is high in the cycle after the accepting edge.
- Steady-state throughput is one byte per 9 cycles (8 FILL + 1 HOLD) with `dout_ready` held at 1.
- All outputs are registered or decoded only from registered state; there is no combinational path from `din_valid` or `ks_bit` to any output. `din_ready` depends on `dout_ready` combinationally; this path is allowed.

## Structure
- Shared package `trivium_pkg`: FSM state enum; `TRIVIUM_WARMUP` = 1152; `KEY_W` = `IV_W` = 80.
- Sub-module `ks_byte_packer`: 8-bit LSB-first shift register plus 3-bit count. Inputs: shift-enable and clear. Output: `full`. Instantiated once.

## Test plan
Sim runs use `WARMUP_CYCLES`=4 and a scripted `ks_bit` driver in place of the core, except the last scenario.
- Reset: assert `rst_n`=0 mid-HOLD → all outputs 0 within the same cycle; IDLE after release; `start` is needed to resume.
- Basic byte: `start`, then post-warm-up bits 1,0,1,1,0,0,1,0 → `ks_byte`=0x4D. `core_en` high exactly 12 cycles; `din_ready` in cycle 13. `din`=0xFF → `dout`=0xB2 with `dout_valid` next cycle.
- Backpressure: hold `dout_ready`=0 through a second HOLD → `din_ready`=0 and `dout` stays 0xB2. Pulse `dout_ready` with `din_valid`=1 and `din`=0x00 → `dout` becomes the second `ks_byte`, `dout_valid` stays 1.
- Abort: `start` after the 3rd FILL bit → `dout_valid`=0 and `core_en` held a fresh 12 cycles. The next byte is built only from bits after the new warm-up.
- Spurious input: `din_valid`=1 during WARMUP and FILL → no transfer and no `dout` change.
- Real core: `WARMUP_CYCLES`=1152 with the Trivium core and a published key/IV vector → first 4 `dout` bytes with `din`=0x00 match the reference keystream.
